bram_host_loader: RTL and testbench

- Host-side master for the processor's shared BRAM port (bram_din / shared_bram_addr / bram_wr_en / bram_dout).
- Accepts burst commands from the PS/AXI glue:
  - Write bursts load instruction memory (BRAM0) or data memories.
  - Read bursts fetch data memory (e.g. MMM result matrix) back into a valid/ready stream.
- Holds the processor in reset while a burst is active.

---
 rtl/bram_host_loader_if.sv | 52 +++++
 rtl/bram_host_loader.sv | 143 ++++++++++++++
 tb/tb_bram_host_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_host_loader_if.sv
// Host command, write/read stream and shared BRAM port bundle for bram_host_loader.
// Optional wstrb lane exists only with BRAM_HOST_LOADER_WSTRB_EN.
interface bram_host_loader_if #(
  parameter int WIDTH   = 32,
  parameter int AW      = 13,
  parameter int NUM_COL = 4,
  parameter int LEN_W   = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [AW-1:0]      cmd_addr;
  logic [LEN_W-1:0]   cmd_len;
  logic               wdata_valid;
  logic               wdata_ready;
  logic [WIDTH-1:0]   wdata;
`ifdef BRAM_HOST_LOADER_WSTRB_EN
  logic [NUM_COL-1:0] wstrb;
`endif
  logic               rdata_valid;
  logic               rdata_ready;
  logic [WIDTH-1:0]   rdata;
  logic               busy;
  logic               done;
  logic               proc_reset;
  logic [WIDTH-1:0]   bram_din;
  logic [AW-1:0]      shared_bram_addr;
  logic [NUM_COL-1:0] bram_wr_en;
  logic [WIDTH-1:0]   bram_dout;

  modport master (
`ifdef BRAM_HOST_LOADER_WSTRB_EN
    output wstrb,
`endif
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wdata_valid, wdata, rdata_ready, bram_dout,
    input  cmd_ready, wdata_ready, rdata_valid, rdata,
    input  busy, done, proc_reset,
    input  bram_din, shared_bram_addr, bram_wr_en
  );

  modport slave (
`ifdef BRAM_HOST_LOADER_WSTRB_EN
    input  wstrb,
`endif
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wdata_valid, wdata, rdata_ready, bram_dout,
    output cmd_ready, wdata_ready, rdata_valid, rdata,
    output busy, done, proc_reset,
    output bram_din, shared_bram_addr, bram_wr_en
  );
endinterface

// File: rtl/bram_host_loader.sv
// Host burst master for the shared BRAM port; holds the core in reset while busy.
// Optional per-byte write strobes: define BRAM_HOST_LOADER_WSTRB_EN.
module bram_host_loader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 1024,
  parameter int NUM_COL  = 4,
  parameter int LEN_W    = 16,
  parameter int READ_LAT = 2
) (
  input logic clk,
  input logic reset,
  bram_host_loader_if.slave bus
);
  localparam int LOGSIZE = $clog2(SIZE);
  localparam int AW      = LOGSIZE + 3;
  localparam int DEPTH   = READ_LAT + 1;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t               state;
  logic [AW-1:0]        cur_addr;
  logic [LEN_W-1:0]     rem;
  logic [LEN_W-1:0]     issue_rem;
  logic [READ_LAT-1:0]  vld;
  logic [WIDTH-1:0]     fifo [DEPTH];
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rp;
  logic [CW-1:0]        cnt;
  logic                 wr_hs;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [NUM_COL-1:0]   wr_mask;

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.proc_reset  = reset | bus.busy;
  assign bus.wdata_ready = (state == WRITE);
  assign bus.rdata_valid = (cnt != '0);
  assign bus.rdata       = fifo[rp];

  assign wr_hs = bus.wdata_valid & bus.wdata_ready;
  assign pop   = bus.rdata_valid & bus.rdata_ready;
  assign push  = vld[READ_LAT-1];

  // Credit counts words buffered or in flight, less the one leaving now.
  assign issue = (state == READ) && (issue_rem != '0) &&
                 ((int'(cnt) + $countones(vld) - int'(pop)) < DEPTH);

`ifdef BRAM_HOST_LOADER_WSTRB_EN
  assign wr_mask = bus.wstrb;
`else
  assign wr_mask = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      cur_addr             <= '0;
      rem                  <= '0;
      issue_rem            <= '0;
      vld                  <= '0;
      bus.done             <= 1'b0;
      bus.bram_wr_en       <= '0;
      bus.bram_din         <= '0;
      bus.shared_bram_addr <= '0;
    end else begin
      bus.done       <= 1'b0;
      bus.bram_wr_en <= '0;
      vld            <= (vld << 1) | READ_LAT'(issue);
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr  <= bus.cmd_addr & ~AW'(3);
            rem       <= bus.cmd_len;
            issue_rem <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else if (bus.cmd_write) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (wr_hs) begin
            bus.shared_bram_addr <= cur_addr;
            bus.bram_din         <= bus.wdata;
            bus.bram_wr_en       <= wr_mask;
            cur_addr             <= cur_addr + AW'(4);
            rem                  <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            bus.shared_bram_addr <= cur_addr;
            cur_addr             <= cur_addr + AW'(4);
            issue_rem            <= issue_rem - LEN_W'(1);
          end
          if (pop) begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return FIFO; credit limit keeps it from overflowing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wp] <= bus.bram_dout;
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (pop) begin
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      end
      if (push && !pop) cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_bram_host_loader.sv
// Self-checking bench for bram_host_loader: vector table plus scoreboard queues.
// Behavioral BRAM returns addr>>2 with a two-cycle issue-to-sample latency.
module tb_bram_host_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  bram_host_loader_if #(
    .WIDTH(32), .AW(13), .NUM_COL(4), .LEN_W(16)
  ) bus ();

  bram_host_loader dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always @(posedge clk)
    bus.bram_dout <= 32'(bus.shared_bram_addr >> 2);

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    int          len;
    int          stall;
    logic [31:0] dbase;
    logic [3:0]  strb;
    int          exp_words;
    logic [12:0] exp_stall_addr;
  } vec_t;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] din;
    logic [3:0]  en;
  } wexp_t;

  vec_t        vecs [8];
  wexp_t       wq [$];
  logic [31:0] rq [$];

  int checks = 0;
  int failures = 0;
  int ev_wr, ev_rd, done_seen, run, max_run;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  // Monitor current outputs against queued expectations, then advance.
  task automatic tick();
    wexp_t e;
    logic [31:0] r;
    if (bus.bram_wr_en != '0) begin
      ev_wr++;
      if (wq.size() == 0) begin
        chk("wr_unexpected", {28'd0, bus.bram_wr_en}, 32'd0);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.shared_bram_addr), 32'(e.addr));
        chk("wr_din", bus.bram_din, e.din);
        chk("wr_en", 32'(bus.bram_wr_en), 32'(e.en));
      end
    end
    if (bus.rdata_valid && bus.rdata_ready) begin
      ev_rd++;
      if (rq.size() == 0) begin
        chk("rd_unexpected", bus.rdata, 32'hFFFF_FFFF);
      end else begin
        r = rq.pop_front();
        chk("rdata", bus.rdata, r);
      end
    end
    if (bus.rdata_valid) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (bus.busy) chk("proc_reset_busy", 32'(bus.proc_reset), 32'd1);
    if (bus.done) done_seen++;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) fail_now("wait_idle");
  endtask

  task automatic run_vec(vec_t v);
    logic [12:0] a;
    logic [12:0] pre_addr;
    logic [3:0]  en;
    int k, n;
    wait_idle();
    a = v.addr & 13'h1FFC;
`ifdef BRAM_HOST_LOADER_WSTRB_EN
    en = v.strb;
`else
    en = 4'hF;
`endif
    for (int i = 0; i < v.len; i++) begin
      if (v.wr) wq.push_back('{a, v.dbase + 32'h11 * i, en});
      else rq.push_back(32'(a >> 2));
      a = a + 13'd4;
    end
    ev_wr = 0; ev_rd = 0; done_seen = 0;
    run = 0; max_run = 0;
    pre_addr = bus.shared_bram_addr;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = 16'(v.len);
    bus.rdata_ready = (v.stall == 0);
    tick();
    bus.cmd_valid = 1'b0;
    if (v.len == 0) begin
      tick();
      chk("len0_done_lat", done_seen, 1);
    end
    if (v.wr) begin
      k = 0; n = 0;
      while (k < v.len && n < 200) begin
        if (bus.wdata_ready) begin
          bus.wdata_valid = 1'b1;
          bus.wdata = v.dbase + 32'h11 * k;
`ifdef BRAM_HOST_LOADER_WSTRB_EN
          bus.wstrb = v.strb;
`endif
          k++;
        end else begin
          bus.wdata_valid = 1'b0;
        end
        tick();
        n++;
      end
      bus.wdata_valid = 1'b0;
      if (k < v.len) fail_now("wr_stream");
    end else if (v.stall > 0) begin
      for (int s = 0; s < v.stall; s++) tick();
      chk("stall_issue_addr", 32'(bus.shared_bram_addr),
          32'(v.exp_stall_addr));
      chk("stall_no_pop", ev_rd, 0);
      chk("stall_valid", 32'(bus.rdata_valid), 32'd1);
      bus.rdata_ready = 1'b1;
    end
    n = 0;
    while (done_seen == 0 && n < 200) begin
      tick();
      n++;
    end
    if (done_seen == 0) fail_now("done_wait");
    tick();
    tick();
    chk("done_once", done_seen, 1);
    chk("back_idle", 32'(bus.cmd_ready), 32'd1);
    chk("words", v.wr ? ev_wr : ev_rd, v.exp_words);
    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
    if (v.len == 0)
      chk("len0_addr", 32'(bus.shared_bram_addr), 32'(pre_addr));
    if (!v.wr && v.stall == 0)
      chk("read_run", max_run, v.len);
  endtask

  initial begin
    vecs[0] = '{1'b1, 13'h0003, 4, 0,  32'h11, 4'hF, 4, 13'h0};
    vecs[1] = '{1'b0, 13'h1000, 5, 10, 32'h0,  4'hF, 5, 13'h1008};
    vecs[2] = '{1'b0, 13'h1020, 8, 0,  32'h0,  4'hF, 8, 13'h0};
    vecs[3] = '{1'b1, 13'h0010, 0, 0,  32'h55, 4'hF, 0, 13'h0};
    vecs[4] = '{1'b1, 13'h1FFC, 2, 0,  32'hA0, 4'hF, 2, 13'h0};
    vecs[5] = '{1'b0, 13'h1FF8, 3, 0,  32'h0,  4'hF, 3, 13'h0};
    vecs[6] = '{1'b1, 13'h0040, 3, 0,  32'hC3, 4'h5, 3, 13'h0};
    vecs[7] = '{1'b1, 13'h0080, 2, 0,  32'h70, 4'hF, 2, 13'h0};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata = '0;
    bus.rdata_ready = 1'b0;
`ifdef BRAM_HOST_LOADER_WSTRB_EN
    bus.wstrb = 4'hF;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(bus.bram_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.shared_bram_addr), 32'd0);
    chk("rst_din", bus.bram_din, 32'd0);
    chk("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_proc_reset", 32'(bus.proc_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_proc_reset", 32'(bus.proc_reset), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of a read burst after two pops.
    wait_idle();
    for (int i = 0; i < 8; i++) rq.push_back(32'h40 + i);
    ev_rd = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 13'h0100;
    bus.cmd_len = 16'd8;
    bus.rdata_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int n = 0; n < 50 && ev_rd < 2; n++) tick();
    if (ev_rd < 2) fail_now("mid_read_pops");
    reset = 1'b1;
    #1;
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mr_rvalid", 32'(bus.rdata_valid), 32'd0);
    chk("mr_wr_en", 32'(bus.bram_wr_en), 32'd0);
    chk("mr_proc_reset", 32'(bus.proc_reset), 32'd1);
    rq.delete();
    @(negedge clk);
    tick();
    reset = 1'b0;
    run_vec(vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
